// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit multiply/divide unit with HI/LO result registers.
// Define MULDIV_DIV_EN to build the div/divu datapath; without it only mult/multu are legal.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dbz
);
    localparam logic [4:0] OP_MULT  = 5'b10011;
    localparam logic [4:0] OP_MULTU = 5'b10101;
`ifdef MULDIV_DIV_EN
    localparam logic [4:0] OP_DIV   = 5'b10110;
    localparam logic [4:0] OP_DIVU  = 5'b10111;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
`ifdef MULDIV_DIV_EN
    logic               r_is_div;
    logic               r_neg_hi;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_step;
`endif

    logic               w_is_mult;
    logic               w_is_div;
    logic               w_signed;
    logic               w_legal;
    logic               w_dbz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_hi_fin;
    logic [WIDTH-1:0]   w_lo_fin;

    always_comb begin
        w_is_mult = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
`ifdef MULDIV_DIV_EN
        w_is_div  = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
        w_signed  = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
        w_dbz     = w_is_div && (srcb == '0);
`else
        w_is_div  = 1'b0;
        w_signed  = (alucontrol == OP_MULT);
        w_dbz     = 1'b0;
`endif
        w_legal   = w_is_mult || w_is_div;
        w_mag_a   = (w_signed && srca[WIDTH-1]) ? -srca : srca;
        w_mag_b   = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    end

    // r_acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_mul_step = {w_sum, r_acc[WIDTH-1:1]};
        w_prod     = r_neg_lo ? -w_mul_step : w_mul_step;
        w_step     = w_mul_step;
        w_hi_fin   = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fin   = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff     = w_shift - {1'b0, r_a};
        w_div_step = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
        if (r_is_div) begin
            w_step   = w_div_step;
            w_hi_fin = r_neg_hi ? -w_div_step[2*WIDTH-1:WIDTH] : w_div_step[2*WIDTH-1:WIDTH];
            w_lo_fin = r_neg_lo ? -w_div_step[WIDTH-1:0]       : w_div_step[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_dbz  <= 1'b0;
                    if (start && w_legal) begin
                        r_cnt    <= '0;
                        r_neg_lo <= w_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        r_is_div <= w_is_div;
                        r_neg_hi <= w_signed && srca[WIDTH-1];
                        r_a      <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
`else
                        r_a      <= w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
`endif
                        if (w_dbz) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= w_step;
                    if (r_cnt == 6'd31) begin
                        r_hi    <= w_hi_fin;
                        r_lo    <= w_lo_fin;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_dbz   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall = (r_state == S_RUN) || ((r_state == S_IDLE) && start && w_legal);
    assign busy  = r_busy;
    assign done  = r_done;
    assign dbz   = r_dbz;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: randomized and directed ops against a plain-arithmetic model.
// Div/divu expectations follow MULDIV_DIV_EN: without it those codes must behave as illegal.
module tb_muldiv_seq;
    localparam logic [4:0] MULT  = 5'b10011;
    localparam logic [4:0] MULTU = 5'b10101;
    localparam logic [4:0] DIV   = 5'b10110;
    localparam logic [4:0] DIVU  = 5'b10111;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dbz;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int unsigned edges;
        int unsigned busy_cycles;
        time         t0;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int unsigned n_checks;
    int unsigned n_pass;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alucontrol(alucontrol),
        .srca      (srca),
        .srcb      (srcb),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .dbz       (dbz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_legal(input logic [4:0] op);
        case (op)
            MULT, MULTU: return 1'b1;
`ifdef MULDIV_DIV_EN
            DIV, DIVU:   return 1'b1;
`endif
            default:     return 1'b0;
        endcase
    endfunction

    task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output exp_t e);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        e.dbz = 1'b0;
        e.edges = 32;
        e.busy_cycles = 32;
        e.t0 = 0;
        case (op)
            MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            DIV, DIVU: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.edges = 0;
                    e.busy_cycles = 0;
                end else if (op == DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   legal;
        @(negedge clk);
        alucontrol = op;
        srca = a;
        srcb = b;
        start = 1'b1;
        legal = model_legal(op);
        #1 chk("stall_at_start", stall, legal);
        if (legal) model_op(op, a, b, e);
        @(posedge clk);
        if (legal) begin
            e.t0 = $time;
            sbq.push_back(e);
        end
        #1 start = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("illegal_busy", busy, 1'b0);
            chk("illegal_done", done, 1'b0);
            chk("illegal_hi", hi, m_hi);
            chk("illegal_lo", lo, m_lo);
        end
    endtask

    // While an op is in flight, inputs are scrambled to show they cannot disturb it.
    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (sbq.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (sbq.size() != 0) begin
                if (busy) chk("stall_in_run", stall, 1'b1);
                alucontrol = 5'($urandom);
                srca = $urandom;
                srcb = $urandom;
                start = 1'($urandom);
            end
        end
        start = 1'b0;
        if (sbq.size() != 0) begin
            chk("op_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        chk("hold_hi", hi, m_hi);
        chk("hold_lo", lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        int unsigned busy_cnt;
        int          edges;
        exp_t        e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_done", done, 1'b0);
                    end else begin
                        e = sbq.pop_front();
                        edges = int'(($time - e.t0 - 5) / 10);
                        chk("hi", hi, e.hi);
                        chk("lo", lo, e.lo);
                        chk("dbz", dbz, e.dbz);
                        chk("latency", 64'(edges), 64'(e.edges));
                        chk("busy_cycles", 64'(busy_cnt), 64'(e.busy_cycles));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [4:0] op;
        n_checks = 0;
        n_pass = 0;
        m_hi = '0;
        m_lo = '0;
        reset = 1'b1;
        start = 1'b0;
        alucontrol = '0;
        srca = '0;
        srcb = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", dbz, 1'b0);
        chk("rst_stall", stall, 1'b0);
        reset = 1'b0;

        launch(MULT,  32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        launch(MULTU, 32'hFFFF_FFFF, 32'h0000_0002); wait_idle();
        launch(DIV,   32'hFFFF_FFF9, 32'h0000_0002); wait_idle();
        launch(MULT,  32'h8000_0000, 32'h8000_0000); wait_idle();
        launch(DIV,   32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        launch(DIVU,  32'h0000_0451, 32'h0000_0020); wait_idle();
        launch(DIVU,  32'h0000_0007, 32'h0000_0000); wait_idle();
        launch(5'b00010, 32'h1234_5678, 32'h0000_0001); wait_idle();

        // Reset sampled while the counter is at 10 abandons the op.
        launch(MULT, 32'h0001_2345, 32'hFFFF_0003);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_hi", hi, 32'd0);
        chk("midrun_rst_lo", lo, 32'd0);
        chk("midrun_rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        launch(MULTU, 32'hDEAD_BEEF, 32'h0000_1001); wait_idle();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0:       op = MULT;
                1:       op = MULTU;
                2:       op = DIV;
                3:       op = DIVU;
                default: op = 5'($urandom);
            endcase
            launch(op, pick(), pick());
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to launch the operation selected by alucontrol.
REQ-005 alucontrol  input  5  op select: 10011 mult, 10101 multu, 10110 div, 10111 divu; any other code is not a muldiv op.
REQ-006 srca  input  32  multiplicand or dividend.
REQ-007 srcb  input  32  multiplier or divisor.
REQ-008 hi  output  32  HI register: upper product half, or remainder.
REQ-009 lo  output  32  LO register: lower product half, or quotient.
REQ-010 busy  output  1  registered; high while state is RUN.
REQ-011 stall  output  1  combinational; high when state is RUN, or when state is IDLE with start high and a legal muldiv code.
REQ-012 done  output  1  registered; one-cycle pulse in DONE.
REQ-013 dbz  output  1  registered; divide-by-zero flag, valid only while done is high.

Function
REQ-014 FSM states: IDLE, RUN, DONE; a 6-bit iteration counter; internal working registers for operands, accumulator and sign.
REQ-015 IDLE: if start is high and the op is legal, latch the operands, op and sign info, clear the counter, and go to RUN; otherwise stay in IDLE.
REQ-016 Exception to REQ-015: a div or divu with srcb==0 goes IDLE->DONE directly with dbz=1; hi and lo are left unchanged.
REQ-017 Signed ops iterate on operand magnitudes; sign correction is applied when hi/lo are written.
REQ-018 mult/multu: radix-2 shift-add, one bit per cycle, 32 RUN cycles.
REQ-019 div/divu: restoring division, one quotient bit per cycle, 32 RUN cycles.
REQ-020 RUN: increment the counter each cycle; on the cycle with counter==31, write the final hi/lo and go to DONE.
REQ-021 Result format: mult/multu give the 64-bit product {hi,lo}; div/divu give lo=quotient, hi=remainder.
REQ-022 Signed division truncates toward zero; the remainder takes the dividend's sign.
REQ-023 Signed boundary: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no flag).
REQ-024 Signed boundary: 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.
REQ-025 DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-026 start in DONE is ignored; a new start is accepted in IDLE only.
REQ-027 Latency: start sampled at edge N gives done high in the cycle after edge N+32, i.e. 33 cycles.
REQ-028 Back-to-back ops are spaced at a minimum of 34 cycles.
REQ-029 Changes to start, alucontrol, srca or srcb while busy have no effect on the running operation.
REQ-030 hi and lo hold their values except at the RUN->DONE write, or at reset.

Reset
REQ-031 When reset is sampled high, including mid-RUN, the next state is IDLE, the counter is cleared, and busy=done=dbz=0, hi=0, lo=0.
REQ-032 Any in-flight operation is abandoned with no partial hi/lo write.
REQ-033 reset takes priority over start in the same cycle.

Configuration
REQ-034 Macro MULDIV_DIV_EN defined: div and divu are supported as specified above.
REQ-035 MULDIV_DIV_EN undefined: codes 10110 and 10111 are treated as illegal (no stall, no busy, no done), dbz is tied to 0, and the divider datapath is not instantiated.

Verification
REQ-036 mult, srca=0xFFFFFFFF, srcb=0x00000002 -> done after 33 cycles with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-037 multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 32 cycles.
REQ-038 div, srca=0xFFFFFFF9 (-7), srcb=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dbz=0.
REQ-039 divu, srca=7, srcb=0, with prior hi=0x11, lo=0x22 -> done and dbz high on the cycle after start, busy never high, hi=0x11, lo=0x22.
REQ-040 mult started, reset asserted at counter==10 -> next cycle busy=0, hi=0, lo=0, done never pulses; a fresh start then completes normally.
REQ-041 start pulsed with alucontrol=00010 (add) -> stall=0, state remains IDLE, hi/lo unchanged.
